data_ram_responder: RTL and testbench
=====================================

DATA_RAM_RESPONDER -- requirements
Module: data_ram_responder

Interface
REQ-001 SHALL have parameter DATASIZE, default 16, data word width.
REQ-002 SHALL have parameter ADDRSIZE, default 11, word address width.
REQ-003 SHALL have parameter MEMWORDS, default 2032, storage words, mapped at 0x000..0x7EF.
REQ-004 SHALL have port clock_i, input, 1, sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_i, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port ramAddr_i, input, ADDRSIZE, word address from the CPU.
REQ-007 SHALL have port ramData_i, input, DATASIZE, write data from the CPU.
REQ-008 SHALL have port wrRam_i, input, 1, write strobe, one access per cycle.
REQ-009 SHALL have port rdRam_i, input, 1, read strobe, one access per cycle.
REQ-010 SHALL have port ramData_o, output, DATASIZE, registered read data to the CPU.
REQ-011 SHALL have port portIn_i, input, DATASIZE, asynchronous external input port.
REQ-012 SHALL have port portOut_o, output, DATASIZE, registered external output port.
REQ-013 SHALL have port timerIrq_o, output, 1, timer-expired flag.

Function
REQ-014 SHALL decode the address map as follows:
- 0x000..0x7EF: storage.
- 0x7F0..0x7FB: reserved; reads return 0, writes are ignored.
- 0x7FC: timer status.
- 0x7FD: timer count.
- 0x7FE: input port.
- 0x7FF: output port.
REQ-015 SHALL write ramData_i to the addressed location at the edge where wrRam_i=1, with no wait states.
REQ-016 SHALL load ramData_o with the addressed value at the edge where rdRam_i=1, giving 1-cycle read latency.
REQ-017 SHALL hold ramData_o unchanged in every cycle with rdRam_i=0.
REQ-018 SHALL, when wrRam_i=1 and rdRam_i=1 in the same cycle, perform both accesses with read-before-write: ramData_o returns the old contents and the write takes effect.
REQ-019 SHALL ignore the upper address bits for storage, accepting no aliasing: addresses at or above MEMWORDS that are not I/O are treated as reserved.
REQ-020 SHALL synchronize portIn_i through two flops; a read of 0x7FE returns the second-stage value.
REQ-021 SHALL load portOut_o on a write to 0x7FF; portOut_o changes at that edge.
REQ-022 SHALL load the 16-bit down-counter with ramData_i on a write to 0x7FD.
REQ-023 SHALL decrement the counter by 1 per cycle while it is nonzero; it saturates at 0 and never wraps.
REQ-024 SHALL set the sticky expired flag on the edge where the counter transitions 1->0.
REQ-025 SHALL drive timerIrq_o directly from the expired flag.
REQ-026 SHALL return the current counter value on a read of 0x7FD.
REQ-027 SHALL return {15'b0, expired} on a read of 0x7FC, and clear the flag at the same edge.
REQ-028 SHALL, when a 1->0 transition coincides with a status read, keep the flag set (set wins); the read returns the pre-edge value.
REQ-029 SHALL, when a counter write coincides with a 1->0 transition, load the written value and not set the flag (write wins).
REQ-030 SHALL treat a counter write of 0 as stopping the timer without setting the flag.

Reset
REQ-031 SHALL, with reset_i=1, immediately force the following state regardless of clock:
- ramData_o=0, portOut_o=0.
- Counter=0, expired flag=0, so timerIrq_o=0.
- Both synchronizer stages=0.
REQ-032 SHALL NOT reset storage contents; they are preserved across reset.
REQ-033 SHALL abort any access presented in the same cycle as reset assertion, with no write effect.
REQ-034 SHALL accept the first access at the first rising edge after reset_i deasserts.

Verification
REQ-035 SHALL pass this scenario: write 0xBEEF to 0x005, then read 0x005 -> ramData_o=0xBEEF one cycle after the rdRam_i edge and held while rdRam_i=0.
REQ-036 SHALL pass this scenario: write 0x1111 to 0x010; next cycle, wr 0x2222 and rd of 0x010 together -> ramData_o=0x1111; a subsequent read returns 0x2222.
REQ-037 SHALL pass this scenario: write 3 to 0x7FD -> counter reads 2,1; timerIrq_o=1 three edges after the write; a read of 0x7FC returns 0x0001, then timerIrq_o=0 and a second read returns 0x0000.
REQ-038 SHALL pass this scenario: write 0xA5A5 to 0x7FF -> portOut_o=0xA5A5 at that edge; set portIn_i=0x1234 -> a read of 0x7FE two or more cycles later returns 0x1234; a read of 0x7F3 returns 0.
REQ-039 SHALL pass this scenario: with counter=1, write 5 to 0x7FD at the expiry edge -> flag stays 0 and the counter reads 4 next cycle.
REQ-040 SHALL pass this scenario: assert reset_i mid-count with portOut_o=0xA5A5 -> outputs, counter and flag are 0 without a clock edge; storage at 0x005 still reads 0xBEEF afterwards.

Source files
------------

// File: rtl/data_ram_responder.sv
// Data-side RAM responder: word storage plus memory-mapped timer and I/O ports
// sitting at the top of the address space. One access per cycle, registered reads.
module data_ram_responder #(
  parameter int DATASIZE = 16,
  parameter int ADDRSIZE = 11,
  parameter int MEMWORDS = 2032
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [ADDRSIZE-1:0] ramAddr_i,
  input  logic [DATASIZE-1:0] ramData_i,
  input  logic                wrRam_i,
  input  logic                rdRam_i,
  output logic [DATASIZE-1:0] ramData_o,
  input  logic [DATASIZE-1:0] portIn_i,
  output logic [DATASIZE-1:0] portOut_o,
  output logic                timerIrq_o
);

  localparam int CNTW = 16;
  localparam logic [ADDRSIZE-1:0] A_STAT = {{(ADDRSIZE-2){1'b1}}, 2'b00};
  localparam logic [ADDRSIZE-1:0] A_CNT  = {{(ADDRSIZE-2){1'b1}}, 2'b01};
  localparam logic [ADDRSIZE-1:0] A_IN   = {{(ADDRSIZE-2){1'b1}}, 2'b10};
  localparam logic [ADDRSIZE-1:0] A_OUT  = {{(ADDRSIZE-2){1'b1}}, 2'b11};

  logic [DATASIZE-1:0] mem [MEMWORDS];

  logic [DATASIZE-1:0] ramData_q, ramData_d;
  logic [DATASIZE-1:0] portOut_q, portOut_d;
  logic [DATASIZE-1:0] sync1_q, sync2_q;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                exp_q, exp_d;

  logic                isMem;
  logic                memWe;
  logic                cntWr;
  logic                statRd;
  logic                expire;
  logic [DATASIZE-1:0] rdVal;

  always_comb begin
    isMem  = int'(ramAddr_i) < MEMWORDS;
    memWe  = wrRam_i && isMem && !reset_i;
    cntWr  = wrRam_i && (ramAddr_i == A_CNT);
    statRd = rdRam_i && (ramAddr_i == A_STAT);
    expire = (cnt_q == CNTW'(1));

    rdVal = '0;
    if (isMem) begin
      rdVal = mem[ramAddr_i];
    end else begin
      case (ramAddr_i)
        A_STAT:  rdVal = DATASIZE'(exp_q);
        A_CNT:   rdVal = DATASIZE'(cnt_q);
        A_IN:    rdVal = sync2_q;
        A_OUT:   rdVal = portOut_q;
        default: rdVal = '0;
      endcase
    end

    ramData_d = rdRam_i ? rdVal : ramData_q;
    portOut_d = (wrRam_i && ramAddr_i == A_OUT) ? ramData_i : portOut_q;

    cnt_d = (cnt_q != '0) ? cnt_q - CNTW'(1) : cnt_q;
    if (cntWr) cnt_d = CNTW'(ramData_i);

    // Expiry beats a same-edge status clear, but a counter write beats expiry.
    exp_d = exp_q;
    if (statRd) exp_d = 1'b0;
    if (expire && !cntWr) exp_d = 1'b1;
  end

  // Storage has no reset; writes are suppressed while reset is held.
  always_ff @(posedge clock_i) begin
    if (memWe) mem[ramAddr_i] <= ramData_i;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ramData_q <= '0;
      portOut_q <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '0;
      exp_q     <= 1'b0;
    end else begin
      ramData_q <= ramData_d;
      portOut_q <= portOut_d;
      sync1_q   <= portIn_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
    end
  end

  assign ramData_o  = ramData_q;
  assign portOut_o  = portOut_q;
  assign timerIrq_o = exp_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: directed scenarios plus a randomized run
// checked against an array-based reference model of the address map.
module tb_data_ram_responder;
  localparam int DW = 16;
  localparam int AW = 11;
  localparam int MW = 2032;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          wr, rd;
  logic [DW-1:0] pin;
  logic [DW-1:0] rdata, pout;
  logic          irq;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state
  logic [15:0] m_mem [0:2047];
  logic [15:0] m_rdata, m_pout, m_cnt, m_s1, m_s2;
  logic        m_exp;

  data_ram_responder #(.DATASIZE(DW), .ADDRSIZE(AW), .MEMWORDS(MW)) dut (
    .clock_i(clk), .reset_i(rst), .ramAddr_i(addr), .ramData_i(wdata),
    .wrRam_i(wr), .rdRam_i(rd), .ramData_o(rdata), .portIn_i(pin),
    .portOut_o(pout), .timerIrq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_rdata = '0; m_pout = '0; m_cnt = '0; m_exp = 1'b0; m_s1 = '0; m_s2 = '0;
  endtask

  // One bus cycle: drive after the falling edge, advance the model at the rising edge.
  task automatic cycle(input bit w, input bit r, input logic [10:0] a, input logic [15:0] d);
    logic [15:0] rv, ncnt;
    logic        nexp;
    @(negedge clk);
    wr = w; rd = r; addr = a; wdata = d;
    @(posedge clk);
    if (!rst) begin
      if (int'(a) < MW)       rv = m_mem[a];
      else if (a == 11'h7FC)  rv = {15'b0, m_exp};
      else if (a == 11'h7FD)  rv = m_cnt;
      else if (a == 11'h7FE)  rv = m_s2;
      else if (a == 11'h7FF)  rv = m_pout;
      else                    rv = 16'h0000;
      ncnt = (m_cnt == 0) ? 16'd0 : m_cnt - 16'd1;
      if (w && a == 11'h7FD) ncnt = d;
      nexp = m_exp;
      if (r && a == 11'h7FC) nexp = 1'b0;
      if (m_cnt == 16'd1 && !(w && a == 11'h7FD)) nexp = 1'b1;
      if (r) m_rdata = rv;
      if (w && int'(a) < MW) m_mem[a] = d;
      if (w && a == 11'h7FF) m_pout = d;
      m_s2 = m_s1; m_s1 = pin;
      m_cnt = ncnt; m_exp = nexp;
    end
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 0; rd = 0; addr = '0; wdata = '0; pin = '0;
    model_reset();
    #3;
    n_cmp++; if (rdata !== 16'h0000) begin n_err++; $display("FAIL reset_rdata: got %h expected %h", rdata, 16'h0000); end
    n_cmp++; if (pout !== 16'h0000) begin n_err++; $display("FAIL reset_pout: got %h expected %h", pout, 16'h0000); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_rw();
    cycle(1, 0, 11'h005, 16'hBEEF);
    cycle(0, 1, 11'h005, 16'h0000);
    n_cmp++; if (rdata !== 16'hBEEF) begin n_err++; $display("FAIL basic_read: got %h expected %h", rdata, 16'hBEEF); end
    cycle(0, 0, 11'h000, 16'h0000);
    cycle(1, 0, 11'h006, 16'h1234);
    n_cmp++; if (rdata !== 16'hBEEF) begin n_err++; $display("FAIL basic_hold: got %h expected %h", rdata, 16'hBEEF); end
  endtask

  task automatic test_back_to_back();
    cycle(1, 0, 11'h010, 16'h1111);
    cycle(1, 1, 11'h010, 16'h2222);
    n_cmp++; if (rdata !== 16'h1111) begin n_err++; $display("FAIL rbw_old: got %h expected %h", rdata, 16'h1111); end
    cycle(0, 1, 11'h010, 16'h0000);
    n_cmp++; if (rdata !== 16'h2222) begin n_err++; $display("FAIL rbw_new: got %h expected %h", rdata, 16'h2222); end
  endtask

  task automatic test_timer();
    cycle(1, 0, 11'h7FD, 16'd3);
    cycle(0, 0, 11'h000, 16'd0);
    cycle(0, 1, 11'h7FD, 16'd0);
    n_cmp++; if (rdata !== 16'd2) begin n_err++; $display("FAIL timer_cnt2: got %h expected %h", rdata, 16'd2); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL timer_early_irq: got %b expected 0", irq); end
    cycle(0, 1, 11'h7FD, 16'd0);
    n_cmp++; if (rdata !== 16'd1) begin n_err++; $display("FAIL timer_cnt1: got %h expected %h", rdata, 16'd1); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL timer_irq: got %b expected 1", irq); end
    cycle(0, 1, 11'h7FC, 16'd0);
    n_cmp++; if (rdata !== 16'h0001) begin n_err++; $display("FAIL status_set: got %h expected %h", rdata, 16'h0001); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL status_clear: got %b expected 0", irq); end
    cycle(0, 1, 11'h7FC, 16'd0);
    n_cmp++; if (rdata !== 16'h0000) begin n_err++; $display("FAIL status_reread: got %h expected %h", rdata, 16'h0000); end
    // expiry coinciding with status read: flag set, read shows pre-edge 0
    cycle(1, 0, 11'h7FD, 16'd1);
    cycle(0, 1, 11'h7FC, 16'd0);
    n_cmp++; if (rdata !== 16'h0000 || irq !== 1'b1) begin n_err++; $display("FAIL set_wins: got %h/%b expected 0000/1", rdata, irq); end
    cycle(0, 1, 11'h7FC, 16'd0);
    n_cmp++; if (rdata !== 16'h0001 || irq !== 1'b0) begin n_err++; $display("FAIL set_wins_clear: got %h/%b expected 0001/0", rdata, irq); end
    // writing 0 stops the timer silently
    cycle(1, 0, 11'h7FD, 16'd2);
    cycle(1, 0, 11'h7FD, 16'd0);
    repeat (3) cycle(0, 0, 11'h000, 16'd0);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL stop_zero: got %b expected 0", irq); end
  endtask

  task automatic test_write_wins();
    cycle(1, 0, 11'h7FD, 16'd2);
    cycle(0, 0, 11'h000, 16'd0);
    cycle(1, 0, 11'h7FD, 16'd5);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL write_wins_irq: got %b expected 0", irq); end
    cycle(0, 0, 11'h000, 16'd0);
    cycle(0, 1, 11'h7FD, 16'd0);
    n_cmp++; if (rdata !== 16'd4) begin n_err++; $display("FAIL write_wins_cnt: got %h expected %h", rdata, 16'd4); end
    cycle(1, 0, 11'h7FD, 16'd0);
  endtask

  task automatic test_io();
    cycle(1, 0, 11'h7FF, 16'hA5A5);
    n_cmp++; if (pout !== 16'hA5A5) begin n_err++; $display("FAIL port_out: got %h expected %h", pout, 16'hA5A5); end
    pin = 16'h1234;
    cycle(0, 0, 11'h000, 16'd0);
    cycle(0, 0, 11'h000, 16'd0);
    cycle(0, 1, 11'h7FE, 16'd0);
    n_cmp++; if (rdata !== 16'h1234) begin n_err++; $display("FAIL port_in: got %h expected %h", rdata, 16'h1234); end
    cycle(0, 1, 11'h7F3, 16'd0);
    n_cmp++; if (rdata !== 16'h0000) begin n_err++; $display("FAIL reserved_7f3: got %h expected %h", rdata, 16'h0000); end
    cycle(1, 0, 11'h7EF, 16'h5A5A);
    cycle(1, 0, 11'h7F0, 16'hFFFF);
    cycle(0, 1, 11'h7EF, 16'd0);
    n_cmp++; if (rdata !== 16'h5A5A) begin n_err++; $display("FAIL last_word: got %h expected %h", rdata, 16'h5A5A); end
    cycle(0, 1, 11'h7F0, 16'd0);
    n_cmp++; if (rdata !== 16'h0000) begin n_err++; $display("FAIL reserved_7f0: got %h expected %h", rdata, 16'h0000); end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 11'h7FD, 16'd2);
    repeat (2) cycle(0, 0, 11'h000, 16'd0);
    cycle(1, 0, 11'h7FD, 16'd100);
    cycle(0, 1, 11'h005, 16'd0);
    n_cmp++; if (irq !== 1'b1 || pout !== 16'hA5A5) begin n_err++; $display("FAIL pre_reset: got %b/%h expected 1/a5a5", irq, pout); end
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (rdata !== 16'h0000 || pout !== 16'h0000 || irq !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got %h/%h/%b expected 0000/0000/0", rdata, pout, irq);
    end
    cycle(1, 0, 11'h005, 16'h0000);
    @(negedge clk); rst = 1'b0;
    cycle(0, 1, 11'h7FD, 16'd0);
    n_cmp++; if (rdata !== 16'h0000) begin n_err++; $display("FAIL reset_cnt: got %h expected %h", rdata, 16'h0000); end
    cycle(0, 1, 11'h005, 16'd0);
    n_cmp++; if (rdata !== 16'hBEEF) begin n_err++; $display("FAIL mem_retained: got %h expected %h", rdata, 16'hBEEF); end
  endtask

  task automatic test_random();
    logic [10:0] a;
    logic [15:0] d;
    bit w, r;
    for (int unsigned i = 0; i < 32; i++) cycle(1, 0, 11'(i), 16'($urandom));
    for (int unsigned i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: a = 11'($urandom_range(0, 31));
        3: a = 11'h7EF;
        4: a = 11'($urandom_range(11'h7F0, 11'h7FB));
        5: a = 11'h7FC;
        6: a = 11'h7FD;
        default: a = 11'($urandom_range(11'h7FE, 11'h7FF));
      endcase
      d = (a == 11'h7FD) ? 16'($urandom_range(0, 6)) : 16'($urandom);
      w = 1'($urandom); r = 1'($urandom);
      if ($urandom_range(0, 9) == 0) pin = 16'($urandom);
      cycle(w, r, a, d);
      n_cmp++; if (rdata !== m_rdata) begin n_err++; $display("FAIL rand_rdata[%0d]: got %h expected %h", i, rdata, m_rdata); end
      n_cmp++; if (pout !== m_pout) begin n_err++; $display("FAIL rand_pout[%0d]: got %h expected %h", i, pout, m_pout); end
      n_cmp++; if (irq !== m_exp) begin n_err++; $display("FAIL rand_irq[%0d]: got %b expected %b", i, irq, m_exp); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_back_to_back();
    test_timer();
    test_write_wins();
    test_io();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
